// File: rtl/crc_rx_check_pkg.sv
// Shared definitions for the serial CRC receive checker and its generator.
// Holds the frame state encoding and the default CRC parameters.
package crc_rx_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PASS = 2'd2
   } state_t;

   localparam int CRC_WIDTH = 16;
   localparam logic [CRC_WIDTH-1:0] CRC_POLY = 16'h8005;

endpackage

// File: rtl/crc_serial_step.sv
// Combinational single-bit CRC update in direct form.
// Shared between the receive checker and the serial generator.
module crc_serial_step
   import crc_rx_check_pkg::*;
#(
   parameter int WIDTH = CRC_WIDTH,
   parameter logic [WIDTH-1:0] POLY = CRC_POLY
) (
   input  logic [WIDTH-1:0] crc,
   input  logic             data,
   output logic [WIDTH-1:0] nxt
);

   logic fb;

   assign fb  = data ^ crc[WIDTH-1];
   assign nxt = (crc << 1) ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_rx_check.sv
// Receive-side serial CRC checker: verifies the trailing CRC field,
// strips it and forwards the payload bits with frame markers.
module crc_rx_check
   import crc_rx_check_pkg::*;
#(
   parameter int WIDTH = CRC_WIDTH,
   parameter logic [WIDTH-1:0] POLY = CRC_POLY,
   parameter logic [WIDTH-1:0] INIT = '0,
   parameter logic [WIDTH-1:0] RESIDUE = '0,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             sof,
   input  logic             eof,
   output logic             out,
   output logic             out_valid,
   output logic             out_sof,
   output logic             out_eof,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic             short_err,
   output logic             abort,
   output logic [LEN_W-1:0] len
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] crc;
   logic [WIDTH-1:0] crc_nxt;
   logic [WIDTH-1:0] crc_sof;
   logic [WIDTH-1:0] dl;
   logic [WIDTH-1:0] dl_nxt;
   logic [CW-1:0]    fill_cnt;
   logic [LEN_W-1:0] pay_cnt;
   logic [LEN_W-1:0] pay_nxt;

   crc_serial_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .crc  (crc),
      .data (in),
      .nxt  (crc_nxt)
   );

   // A sof bit is folded into a freshly loaded INIT, not the old register.
   crc_serial_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step_sof (
      .crc  (INIT),
      .data (in),
      .nxt  (crc_sof)
   );

   assign dl_nxt  = (dl << 1) | WIDTH'(in);
   assign pay_nxt = (&pay_cnt) ? pay_cnt : pay_cnt + LEN_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         crc       <= INIT;
         dl        <= '0;
         fill_cnt  <= '0;
         pay_cnt   <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         done      <= 1'b0;
         crc_ok    <= 1'b0;
         crc_err   <= 1'b0;
         short_err <= 1'b0;
         abort     <= 1'b0;
         len       <= '0;
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         done      <= 1'b0;
         abort     <= 1'b0;
         if (in_valid) begin
            if (sof) begin
               abort     <= (state != IDLE);
               crc       <= crc_sof;
               dl        <= dl_nxt;
               fill_cnt  <= CNT_ONE;
               pay_cnt   <= '0;
               crc_ok    <= 1'b0;
               crc_err   <= 1'b0;
               short_err <= 1'b0;
               len       <= '0;
               if (eof) begin
                  done      <= 1'b1;
                  crc_err   <= 1'b1;
                  short_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  state <= (WIDTH == 1) ? PASS : FILL;
               end
            end else begin
               unique case (state)
                  IDLE: begin
                  end
                  FILL: begin
                     crc      <= crc_nxt;
                     dl       <= dl_nxt;
                     fill_cnt <= fill_cnt + CNT_ONE;
                     if (eof) begin
                        done      <= 1'b1;
                        crc_err   <= 1'b1;
                        short_err <= 1'b1;
                        state     <= IDLE;
                     end else if (fill_cnt == FILL_LAST) begin
                        state <= PASS;
                     end
                  end
                  PASS: begin
                     crc       <= crc_nxt;
                     dl        <= dl_nxt;
                     out       <= dl[WIDTH-1];
                     out_valid <= 1'b1;
                     out_sof   <= (pay_cnt == '0);
                     pay_cnt   <= pay_nxt;
                     if (eof) begin
                        out_eof   <= 1'b1;
                        done      <= 1'b1;
                        crc_ok    <= (crc_nxt == RESIDUE);
                        crc_err   <= (crc_nxt != RESIDUE);
                        short_err <= 1'b0;
                        len       <= pay_nxt;
                        state     <= IDLE;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_crc_rx_check.sv
// Self-checking bench for crc_rx_check: table vectors, corner sequences
// and random frames against a polynomial long-division model.
module tb_crc_rx_check;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in = 1'b0;
   logic        in_valid = 1'b0;
   logic        sof = 1'b0;
   logic        eof = 1'b0;
   logic        out, out_valid, out_sof, out_eof;
   logic        done, crc_ok, crc_err, short_err, abort;
   logic [15:0] len;

   crc_rx_check #(
      .WIDTH   (16),
      .POLY    (16'h8005),
      .INIT    (16'h0000),
      .RESIDUE (16'h0000),
      .LEN_W   (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .in_valid  (in_valid),
      .sof       (sof),
      .eof       (eof),
      .out       (out),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .done      (done),
      .crc_ok    (crc_ok),
      .crc_err   (crc_err),
      .short_err (short_err),
      .abort     (abort),
      .len       (len)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [95:0]  val;
      int           n;
      bit           ok;
      bit           shrt;
      int           plen;
   } vec_t;

   vec_t        vt[8];
   int          checks = 0;
   int          errors = 0;
   int          abort_cnt = 0;
   int          abort_base = 0;
   logic [2:0]  got_bits[$];
   logic [18:0] got_done[$];
   bit          frame_q[$];

   always @(negedge clk) begin
      if (out_valid) got_bits.push_back({out, out_sof, out_eof});
      if (done) got_done.push_back({crc_ok, crc_err, short_err, len});
      if (abort) abort_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   // Remainder of the bit polynomial (first bit = highest power) mod x^16+0x8005.
   function automatic logic [15:0] pmod(input bit q[$], input int n);
      logic [16:0] r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         r = {r[15:0], q[i]};
         if (r[16]) r = r ^ 17'h18005;
      end
      return r[15:0];
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input bit b, input bit s, input bit e);
      in = b;
      sof = s;
      eof = e;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sof = 1'b0;
      eof = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input int maxgap,
                             input bit with_eof);
      for (int i = lo; i < hi; i++) begin
         if (maxgap > 0 && i != lo) idle($urandom_range(maxgap, 0));
         beat(frame_q[i], i == 0, with_eof && (i == frame_q.size() - 1));
      end
   endtask

   task automatic load_val(input logic [95:0] v, input int n);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(v[n-1-i]);
   endtask

   task automatic drain();
      while (got_bits.size() > 0) void'(got_bits.pop_front());
      while (got_done.size() > 0) void'(got_done.pop_front());
   endtask

   task automatic check_frame(input string nm, input bit ok, input bit shrt,
                              input int plen, input int exp_abort);
      logic [2:0]  v;
      logic [18:0] d;
      idle(3);
      chk({nm, ".n_out"}, 32'(got_bits.size()), 32'(plen));
      for (int i = 0; i < plen; i++) begin
         if (got_bits.size() > 0) begin
            v = got_bits.pop_front();
            chk({nm, ".bit"}, 32'(v[2]), 32'(frame_q[i]));
            chk({nm, ".out_sof"}, 32'(v[1]), 32'(i == 0));
            chk({nm, ".out_eof"}, 32'(v[0]), 32'(i == plen - 1));
         end
      end
      chk({nm, ".n_done"}, 32'(got_done.size()), 32'(1));
      if (got_done.size() > 0) begin
         d = got_done.pop_front();
         chk({nm, ".crc_ok"}, 32'(d[18]), 32'(ok));
         chk({nm, ".crc_err"}, 32'(d[17]), 32'(!ok));
         chk({nm, ".short_err"}, 32'(d[16]), 32'(shrt));
         chk({nm, ".len"}, 32'(d[15:0]), 32'(plen));
      end
      chk({nm, ".ok_held"}, 32'(crc_ok), 32'(ok));
      chk({nm, ".abort"}, 32'(abort_cnt - abort_base), 32'(exp_abort));
      abort_base = abort_cnt;
      drain();
   endtask

   initial begin
      bit          pay[$];
      logic [15:0] c;
      int          p, n, plen;
      bit          ok;

      vt[0] = '{"t1", 96'h018005, 24, 1'b1, 1'b0, 8};
      vt[1] = '{"t2", 96'h313233343536373839FEE8, 88, 1'b1, 1'b0, 72};
      vt[2] = '{"t3_flip", 96'h118005, 24, 1'b0, 1'b0, 8};
      vt[3] = '{"crc_bit", 96'h018004, 24, 1'b0, 1'b0, 8};
      vt[4] = '{"exact_w", 96'h8005, 16, 1'b0, 1'b1, 0};
      vt[5] = '{"w_plus1", 96'h18005, 17, 1'b1, 1'b0, 1};
      vt[6] = '{"zeros17", 96'h0, 17, 1'b1, 1'b0, 1};
      vt[7] = '{"ten", 96'h2AA, 10, 1'b0, 1'b1, 0};

      idle(2);
      chk("reset_outs", 32'({out, out_valid, out_sof, out_eof, done, crc_ok,
                             crc_err, short_err, abort, len}), 32'(0));
      rst = 1'b0;
      idle(2);

      for (int k = 0; k < 8; k++) begin
         load_val(vt[k].val, vt[k].n);
         send_range(0, vt[k].n, 0, 1'b1);
         check_frame(vt[k].name, vt[k].ok, vt[k].shrt, vt[k].plen, 0);
      end

      // 1-bit frame: sof and eof on the same beat
      load_val(96'h1, 1);
      send_range(0, 1, 0, 1'b1);
      check_frame("one_bit", 1'b0, 1'b1, 0, 0);

      // results clear on the next accepted sof
      load_val(vt[0].val, 24);
      send_range(0, 24, 0, 1'b1);
      check_frame("pre_clr", 1'b1, 1'b0, 8, 0);
      send_range(0, 1, 0, 1'b0);
      chk("clr_ok", 32'(crc_ok), 32'(0));
      chk("clr_len", 32'(len), 32'(0));
      send_range(1, 24, 0, 1'b1);
      check_frame("post_clr", 1'b1, 1'b0, 8, 0);

      // sof inside an open frame
      load_val(vt[1].val, 88);
      send_range(0, 30, 0, 1'b0);
      idle(2);
      chk("drop.n_out", 32'(got_bits.size()), 32'(14));
      chk("drop.n_done", 32'(got_done.size()), 32'(0));
      drain();
      load_val(vt[0].val, 24);
      send_range(0, 24, 0, 1'b1);
      check_frame("after_abort", 1'b1, 1'b0, 8, 1);

      // valid gaps
      load_val(vt[1].val, 88);
      send_range(0, 88, 3, 1'b1);
      check_frame("t2_gaps", 1'b1, 1'b0, 72, 0);

      // reset mid-frame
      load_val(vt[0].val, 24);
      send_range(0, 20, 0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_outs", 32'({out, out_valid, out_sof, out_eof, done, crc_ok,
                              crc_err, short_err, abort, len}), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);
      chk("midrst.n_done", 32'(got_done.size()), 32'(0));
      chk("midrst.abort", 32'(abort_cnt - abort_base), 32'(0));
      drain();
      send_range(0, 24, 0, 1'b1);
      check_frame("after_rst", 1'b1, 1'b0, 8, 0);

      // random frames against the division model
      for (int r = 0; r < 40; r++) begin
         frame_q.delete();
         pay.delete();
         if ($urandom_range(99, 0) < 15) begin
            n = $urandom_range(16, 1);
            for (int i = 0; i < n; i++) frame_q.push_back(1'($urandom));
         end else begin
            p = $urandom_range(40, 1);
            for (int i = 0; i < p; i++) pay.push_back(1'($urandom));
            for (int i = 0; i < p; i++) frame_q.push_back(pay[i]);
            for (int i = 0; i < 16; i++) pay.push_back(1'b0);
            c = pmod(pay, p + 16);
            for (int i = 15; i >= 0; i--) frame_q.push_back(c[i]);
            if ($urandom_range(99, 0) < 25) begin
               n = $urandom_range(p + 15, 0);
               frame_q[n] = !frame_q[n];
            end
         end
         n = frame_q.size();
         plen = (n > 16) ? n - 16 : 0;
         ok = (n > 16) && (pmod(frame_q, n) == 16'h0);
         send_range(0, n, 2, 1'b1);
         check_frame("rand", ok, n <= 16, plen, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
